// File: rtl/pwm_pkg.sv
// Shared constants, channel state encoding and step helper for the PWM fade sequencer.
package pwm_pkg;

    localparam int          DUTY_W     = 8;
    localparam logic [7:0]  PERIOD_MAX = 8'hFF;
    localparam logic [7:0]  DUTY_MAX   = 8'hFF;
    localparam logic [7:0]  DUTY_MIN   = 8'h00;

    // Implicit per-channel state, derived from cur versus tgt.
    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_RAMP_UP = 2'd1,
        CH_RAMP_DN = 2'd2
    } chan_state_t;

    // One LSB toward tgt, clamped at the duty endpoints so a step can never wrap.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt
    );
        logic [DUTY_W-1:0] res;
        res = cur;
        if (cur < tgt && cur != DUTY_MAX)
            res = cur + 8'd1;
        else if (cur > tgt && cur != DUTY_MIN)
            res = cur - 8'd1;
        return res;
    endfunction

endpackage

// File: rtl/pwm_fade_chan.sv
// One fade channel: current/target duty, step divider and prescaler, busy/done flags.
module pwm_fade_chan
    import pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              period_tick,
    input  logic              sel_wr,
    input  logic [DUTY_W-1:0] wr_target,
    input  logic [DUTY_W-1:0] wr_div,
    input  logic              wr_immediate,
    output logic [DUTY_W-1:0] pulse_width,
    output logic              busy,
    output logic              done
);

    logic [DUTY_W-1:0] cur_reg;
    logic [DUTY_W-1:0] tgt_reg;
    logic [DUTY_W-1:0] div_reg;
    logic [DUTY_W-1:0] pre_reg;
    logic              done_reg;
    logic [DUTY_W-1:0] step_next;
    chan_state_t       state;

    // Classify the channel and precompute the value a step would produce.
    always_comb begin
        state = CH_IDLE;
        if (cur_reg < tgt_reg)
            state = CH_RAMP_UP;
        else if (cur_reg > tgt_reg)
            state = CH_RAMP_DN;
        step_next = step_toward(cur_reg, tgt_reg);
    end

    // Writes take priority over a coincident period tick; steps happen only on ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_reg  <= '0;
            tgt_reg  <= '0;
            div_reg  <= '0;
            pre_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (sel_wr) begin
                tgt_reg <= wr_target;
                div_reg <= wr_div;
                pre_reg <= '0;
                if (wr_immediate)
                    cur_reg <= wr_target;
            end else if (period_tick) begin
                if (state == CH_IDLE) begin
                    pre_reg <= '0;
                end else if (pre_reg == div_reg) begin
                    pre_reg  <= '0;
                    cur_reg  <= step_next;
                    done_reg <= (step_next == tgt_reg);
                end else begin
                    pre_reg <= pre_reg + 8'd1;
                end
            end
        end
    end

    assign pulse_width = cur_reg;
    assign busy        = (state != CH_IDLE);
    assign done        = done_reg;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Multi-channel PWM brightness sequencer: period counter, write decode, channel array.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int CH  = 4,
    parameter int CHW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CHW-1:0]       wr_ch,
    input  logic [DUTY_W-1:0]    wr_target,
    input  logic [DUTY_W-1:0]    wr_div,
    input  logic                 wr_immediate,
    output logic [DUTY_W*CH-1:0] pulse_width,
    output logic [CH-1:0]        busy,
    output logic [CH-1:0]        done,
    output logic                 period_tick
);

    logic [7:0]    period_cnt_reg;
    logic          wr_in_range;
    logic [CH-1:0] sel_wr;

    // Free-running period counter, aligned with the 256-clock PWM period.
    always_ff @(posedge clk) begin
        if (rst)
            period_cnt_reg <= '0;
        else
            period_cnt_reg <= period_cnt_reg + 8'd1;
    end

    assign period_tick = (period_cnt_reg == PERIOD_MAX);

    // Extra bit so CH == 2**CHW still compares correctly; out-of-range writes are dropped.
    assign wr_in_range = ({1'b0, wr_ch} < (CHW+1)'(CH));

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_chan
            assign sel_wr[gi] = wr_en && wr_in_range && (wr_ch == CHW'(gi));

            pwm_fade_chan u_chan (
                .clk          (clk),
                .rst          (rst),
                .period_tick  (period_tick),
                .sel_wr       (sel_wr[gi]),
                .wr_target    (wr_target),
                .wr_div       (wr_div),
                .wr_immediate (wr_immediate),
                .pulse_width  (pulse_width[DUTY_W*gi +: DUTY_W]),
                .busy         (busy[gi]),
                .done         (done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: idle timing, ramps, immediate loads, write/tick collision, reset.
module tb_pwm_fade_ctrl;

    localparam int CH  = 4;
    localparam int CHW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [7:0]    wr_target = '0;
    logic [7:0]    wr_div = '0;
    logic          wr_immediate = 1'b0;
    logic [8*CH-1:0] pulse_width;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;
    logic          period_tick;

    int checks = 0;
    int errors = 0;

    pwm_fade_ctrl #(.CH(CH), .CHW(CHW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_target    (wr_target),
        .wr_div       (wr_div),
        .wr_immediate (wr_immediate),
        .pulse_width  (pulse_width),
        .busy         (busy),
        .done         (done),
        .period_tick  (period_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic do_write(input logic [CHW-1:0] ch, input logic [7:0] t,
                            input logic [7:0] d, input logic imm);
        wr_en = 1'b1; wr_ch = ch; wr_target = t; wr_div = d; wr_immediate = imm;
        @(negedge clk);
        wr_en = 1'b0; wr_immediate = 1'b0;
    endtask

    // Advance at negedges until period_tick is high (bounded).
    task automatic wait_tick();
        int n;
        n = 0;
        while (period_tick !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tick_seen", 32'(period_tick), 32'd1);
    endtask

    initial begin
        int n_ticks;
        int first_t;
        int second_t;
        int idle_bad;
        int cnt;
        logic [31:0] pw_snap;
        logic [CH-1:0] busy_snap;

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        chk("rst_pw", pulse_width, 32'h0);
        chk("rst_flags", {24'h0, busy, done}, 32'h0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        rst = 1'b0;

        // ---- idle 600 clks: ticks at 255 and 511 only ----
        n_ticks = 0; first_t = -1; second_t = -1; idle_bad = 0;
        for (int i = 0; i < 600; i++) begin
            if (period_tick) begin
                if (n_ticks == 0) first_t = i;
                else if (n_ticks == 1) second_t = i;
                n_ticks++;
            end
            if (pulse_width != 0 || busy != 0 || done != 0) idle_bad = 1;
            @(negedge clk);
        end
        chk("idle_nticks", 32'(n_ticks), 32'd2);
        chk("idle_tick1", 32'(first_t), 32'd255);
        chk("idle_tick2", 32'(second_t), 32'd511);
        chk("idle_quiet", 32'(idle_bad), 32'd0);

        // ---- ch0 target 4, div 0: 1,2,3,4 on successive ticks ----
        do_write(3'd0, 8'h04, 8'h00, 1'b0);
        chk("c0_start", {24'h0, pulse_width[7:0]}, 32'h0);
        chk("c0_busy", {28'h0, busy}, 32'h1);
        for (int v = 1; v <= 4; v++) begin
            wait_tick();
            @(negedge clk);
            chk("c0_step", {24'h0, pulse_width[7:0]}, 32'(v));
            if (v == 4) begin
                chk("c0_done", {28'h0, done}, 32'h1);
                chk("c0_busy_clr", {28'h0, busy}, 32'h0);
            end else begin
                chk("c0_nodone", {28'h0, done}, 32'h0);
            end
        end
        @(negedge clk);
        chk("c0_done_once", {28'h0, done}, 32'h0);

        // ---- ch1 target 2, div 2: step every third tick ----
        do_write(3'd1, 8'h02, 8'h02, 1'b0);
        chk("c1_busy", {28'h0, busy}, 32'h2);
        for (int t = 1; t <= 6; t++) begin
            wait_tick();
            @(negedge clk);
            chk("c1_val", {24'h0, pulse_width[15:8]}, (t < 3) ? 32'd0 : ((t < 6) ? 32'd1 : 32'd2));
            chk("c1_done", {28'h0, done}, (t == 6) ? 32'h2 : 32'h0);
        end

        // ---- ch2 immediate to FF, then down to FC; ch1 down to 0 ----
        do_write(3'd2, 8'hFF, 8'h00, 1'b1);
        chk("c2_jump", {24'h0, pulse_width[23:16]}, 32'hFF);
        chk("c2_imm_flags", {24'h0, busy, done}, 32'h0);
        @(negedge clk);
        chk("c2_imm_nodone", {28'h0, done}, 32'h0);
        do_write(3'd2, 8'hFC, 8'h00, 1'b0);
        do_write(3'd1, 8'h00, 8'h00, 1'b0);
        chk("c12_busy", {28'h0, busy}, 32'h6);
        for (int t = 1; t <= 4; t++) begin
            wait_tick();
            @(negedge clk);
            chk("c2_val", {24'h0, pulse_width[23:16]},
                (t == 1) ? 32'hFE : ((t == 2) ? 32'hFD : 32'hFC));
            chk("c1_down", {24'h0, pulse_width[15:8]}, (t == 1) ? 32'd1 : 32'd0);
            chk("c12_done", {28'h0, done},
                (t == 2) ? 32'h2 : ((t == 3) ? 32'h4 : 32'h0));
        end

        // ---- ch3 write collides with tick; ch0 steps normally ----
        do_write(3'd3, 8'h10, 8'h00, 1'b0);
        do_write(3'd0, 8'h10, 8'h00, 1'b0);
        wait_tick();
        @(negedge clk);
        chk("col_t1", pulse_width, 32'h01FC0005);
        wait_tick();
        do_write(3'd3, 8'h20, 8'h00, 1'b0);
        chk("col_t2", pulse_width, 32'h01FC0006);
        wait_tick();
        @(negedge clk);
        chk("col_t3", pulse_width, 32'h02FC0007);
        chk("col_busy", {28'h0, busy}, 32'h9);

        // ---- wr_ch == CH is ignored ----
        pw_snap = pulse_width;
        busy_snap = busy;
        do_write(3'(CH), 8'h55, 8'h00, 1'b1);
        @(negedge clk);
        chk("oor_pw", pulse_width, 32'h02FC0007);
        chk("oor_busy", {28'h0, busy}, 32'h9);
        chk("oor_stable", {31'h0, (pulse_width == pw_snap && busy == busy_snap)}, 32'h1);

        // ---- ch0 toward 80, reset mid-ramp ----
        do_write(3'd0, 8'h80, 8'h00, 1'b0);
        wait_tick();
        @(negedge clk);
        chk("c0_ramp", {24'h0, pulse_width[7:0]}, 32'h08);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_pw", pulse_width, 32'h0);
        chk("mid_rst_flags", {24'h0, busy, done}, 32'h0);
        chk("mid_rst_tick", 32'(period_tick), 32'd0);
        cnt = 0;
        while (period_tick !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (done != 0) idle_bad = 1;
        end
        chk("rst_cnt_restart", 32'(cnt), 32'd255);
        chk("rst_no_done", 32'(idle_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
